// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default link constants
package uart_pkg;
    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 10;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// tx_bit_timer: bit-period timer, bit_tick high in the last cycle of each period
module tx_bit_timer import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    logic [TW-1:0] cnt_q, cnt_d;
    assign bit_tick = enable && (cnt_q == TW'(CLKS_PER_BIT - 1));
    // count cycles within the current bit, wrapping at the end of the period
    always_comb cnt_d = (clear || bit_tick) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    // timer register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART frame transmitter; define UART_TX_PARITY_EN to insert an even-parity bit
module uart_tx import uart_pkg::*; #(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_out
);
    localparam int CW = $clog2(DATA_BITS + 1);
`ifdef UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
`else
    localparam tx_state_t AFTER_DATA = STOP;
`endif
    tx_state_t state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic serial_q, serial_d, bit_tick, par_bit;
    tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .enable  (state_q != IDLE),
        .bit_tick(bit_tick)
    );
`ifdef UART_TX_PARITY_EN
    logic par_q;
    // parity is captured at accept because the shift register consumes the payload
    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else if (state_q == IDLE && tx_start) par_q <= ^tx_data;
    end
    assign par_bit = par_q;
`else
    assign par_bit = 1'b1;
`endif
    // next-state, shift and bit-count logic; line level is derived from the next state
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (tx_start) begin
                shift_d = tx_data;
                state_d = START;
            end
            START: if (bit_tick) state_d = DATA;
            DATA: if (bit_tick) begin
                shift_d = shift_q >> 1;
                cnt_d = (cnt_q == CW'(DATA_BITS - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) state_d = STOP;
`endif
            STOP: if (bit_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        serial_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_bit : 1'b1;
    end
    // state, datapath and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q <= cnt_d;
            serial_q <= serial_d;
        end
    end
    assign tx_busy = state_q != IDLE;
    assign tx_done = (state_q == STOP) && bit_tick;
    assign serial_out = serial_q;
endmodule
